// File: rtl/barrel_dr_sequencer.sv
// barrel_dr_sequencer: valid/ready front end that runs one dual-rail DATA/NULL cycle on the Barrel shifter per request
module barrel_dr_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_data,
  input  logic [4:0] req_ctl,
  output logic [7:0] dr_a,
  output logic [9:0] dr_ctl,
  input  logic [7:0] dr_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, DATA, NUL, RESP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] s, a_enc;
  logic [9:0] c_enc;
  logic [7:0] cnt;
  logic [3:0] res;
  logic all_data, any_ill, all_null, timed_out;
  assign s = sync[SYNC_STAGES-1];
  assign all_null = ~|s;
  assign timed_out = cnt == 8'(TIMEOUT);
  always_comb begin
    a_enc = '0;
    c_enc = '0;
    for (int i = 0; i < 4; i++) a_enc[2*i+:2] = req_data[i] ? 2'b10 : 2'b01;
    for (int i = 0; i < 5; i++) c_enc[2*i+:2] = req_ctl[i] ? 2'b10 : 2'b01;
  end
  always_comb begin
    all_data = 1'b1;
    any_ill = 1'b0;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      all_data = all_data & (s[2*i] ^ s[2*i+1]);
      any_ill = any_ill | (&s[2*i+:2]);
      res[i] = s[2*i+1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else begin
      sync[0] <= dr_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      dr_a <= '0;
      dr_ctl <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      err_cnt <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            dr_a <= a_enc;
            dr_ctl <= c_enc;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            req_ready <= 1'b0;
            cnt <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (any_ill || all_data || timed_out) begin
            rsp_data <= (all_data && !any_ill) ? res : 4'd0;
            rsp_err <= any_ill || !all_data;
            dr_a <= '0;
            dr_ctl <= '0;
            cnt <= '0;
            state <= NUL;
          end else cnt <= cnt + 8'd1;
        end
        NUL: begin
          if (all_null || timed_out) begin
            rsp_err <= rsp_err || !all_null;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else cnt <= cnt + 8'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            if (rsp_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
